// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image-stream blocks.
//   CW            : coordinate width used for window origin/size and counters
//   window_t      : crop window record (origin x,y and size w,h)
//   pixelBusWidth : width of a pixel bus made of numCh channels of dataWidth
// ---------------------------------------------------------------------------
package img_pkg;

  localparam int CW = 10;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } window_t;

  function automatic int pixelBusWidth(input int dataWidth, input int numCh);
    return dataWidth * numCh;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// ---------------------------------------------------------------------------
// stream_reg_slice
// Single-entry registered valid/ready stage. A beat offered on the input
// appears on the output one cycle later and is held there unchanged until
// the consumer takes it.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : upstream handshake, in_data payload
//   out_valid/out_ready: downstream handshake, out_data payload
// ---------------------------------------------------------------------------
module stream_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // The slot can take a new beat when it is empty or is being drained this
  // cycle; this keeps full throughput with only one register.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Load on an input handshake, empty on an output handshake, otherwise hold.
  // Reset drops any beat that was waiting, including a stalled one.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_crop.sv
// ---------------------------------------------------------------------------
// stream_crop
// Crops a rectangular window out of a raster pixel stream.
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_x/y/w/h, cfg_load    : requested window, captured into a shadow set;
//                              the shadow goes live on the next accepted s_sof
//   s_data/valid/ready/sof/eol : input pixel stream
//   m_data/valid/ready/sof/eol/eof : cropped output stream, registered
//   cfg_err                  : sticky, an invalid window was activated
//   busy                     : a frame is in progress and its window is not
//                              yet complete
// ---------------------------------------------------------------------------
module stream_crop
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 1,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CW         = img_pkg::CW
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [CW-1:0]                             cfg_x,
  input  logic [CW-1:0]                             cfg_y,
  input  logic [CW-1:0]                             cfg_w,
  input  logic [CW-1:0]                             cfg_h,
  input  logic                                      cfg_load,
  input  logic [pixelBusWidth(DATA_WIDTH,NUM_CH)-1:0] s_data,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic                                      s_sof,
  input  logic                                      s_eol,
  output logic [pixelBusWidth(DATA_WIDTH,NUM_CH)-1:0] m_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic                                      m_sof,
  output logic                                      m_eol,
  output logic                                      m_eof,
  output logic                                      cfg_err,
  output logic                                      busy
);

  localparam int PW = pixelBusWidth(DATA_WIDTH, NUM_CH);

  localparam logic [1:0] WAIT_SOF = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;

  localparam logic [CW:0]   IMG_W_EXT = (CW+1)'(IMG_WIDTH);
  localparam logic [CW:0]   IMG_H_EXT = (CW+1)'(IMG_HEIGHT);
  localparam logic [CW:0]   ONE_EXT   = (CW+1)'(1);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] X_LAST    = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(IMG_HEIGHT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  window_t       shadow_q, shadow_d, active_q, active_d;
  logic          cfgErr_q, cfgErr_d;

  logic          accept;
  logic          sliceReady;
  logic [CW-1:0] beatX, beatY;
  window_t       win;
  logic [CW:0]   winEndX, winEndY;
  logic          winValid, inWindow, frameLive;
  logic          isSof, isEol, isEof;
  logic          fwd;

  assign s_ready = sliceReady;
  assign accept  = s_valid && sliceReady;
  assign cfg_err = cfgErr_q;
  assign busy    = (state_q == ACTIVE);

  // An s_sof beat is always (0,0) and uses the shadow window, since that is
  // the window being activated by this very beat.
  always_comb begin
    beatX = s_sof ? '0 : x_q;
    beatY = s_sof ? '0 : y_q;
    win   = s_sof ? shadow_q : active_q;
  end

  // Window geometry evaluated one bit wider so origin+size cannot wrap.
  always_comb begin
    winEndX  = {1'b0, win.x} + {1'b0, win.w};
    winEndY  = {1'b0, win.y} + {1'b0, win.h};
    winValid = (win.w != '0) && (win.h != '0) &&
               (winEndX <= IMG_W_EXT) && (winEndY <= IMG_H_EXT);
    inWindow = (beatX >= win.x) && ({1'b0, beatX} < winEndX) &&
               (beatY >= win.y) && ({1'b0, beatY} < winEndY);
    isSof    = (beatX == win.x) && (beatY == win.y);
    isEol    = ({1'b0, beatX} == winEndX - ONE_EXT);
    isEof    = isEol && ({1'b0, beatY} == winEndY - ONE_EXT);
  end

  // A frame only produces output while ACTIVE, or on its own s_sof beat when
  // the window being activated is valid.
  assign frameLive = s_sof ? winValid : (state_q == ACTIVE);
  assign fwd       = accept && frameLive && inWindow;

  // Next-state logic: raster counters, shadow/active window sets, sticky
  // error and frame state. Any accepted s_sof restarts the frame, which also
  // abandons a partially delivered one without an end-of-frame marker.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cfgErr_d = cfgErr_q;

    if (cfg_load) begin
      shadow_d = '{x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h};
    end

    if (accept) begin
      if (s_eol || (beatX == X_LAST)) begin
        x_d = '0;
        y_d = (beatY == Y_LAST) ? beatY : beatY + ONE;
      end else begin
        x_d = beatX + ONE;
        y_d = beatY;
      end

      if (s_sof) begin
        active_d = shadow_q;
        if (!winValid) begin
          cfgErr_d = 1'b1;
          state_d  = DRAIN;
        end else begin
          state_d = ACTIVE;
        end
      end

      if (fwd && isEof) begin
        state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_SOF;
      x_q      <= '0;
      y_q      <= '0;
      shadow_q <= '0;
      active_q <= '0;
      cfgErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cfgErr_q <= cfgErr_d;
    end
  end

  // Output register stage; flags travel with the pixel as one payload.
  stream_reg_slice #(
    .WIDTH(PW + 3)
  ) u_outSlice (
    .clk      (clk),
    .rst      (rst),
    .in_valid (fwd),
    .in_ready (sliceReady),
    .in_data  ({isEof, isEol, isSof, s_data}),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data ({m_eof, m_eol, m_sof, m_data})
  );

endmodule

// File: tb/tb_stream_crop.sv
// ---------------------------------------------------------------------------
// tb_stream_crop
// Self-checking bench for stream_crop on an 8x6 frame. Pixel data encodes
// its own position as y*16+x so every output beat identifies its source.
// ---------------------------------------------------------------------------
module tb_stream_crop;

  localparam int IW  = 8;
  localparam int IH  = 6;
  localparam int CWB = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [CWB-1:0] cfg_x, cfg_y, cfg_w, cfg_h;
  logic           cfg_load;
  logic [7:0]     s_data;
  logic           s_valid, s_ready, s_sof, s_eol;
  logic [7:0]     m_data;
  logic           m_valid, m_ready, m_sof, m_eol, m_eof;
  logic           cfg_err, busy;

  logic toggleEn    = 1'b0;
  logic togglePhase = 1'b0;
  logic readyLevel  = 1'b1;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  typedef struct {
    beat_t cur;
    beat_t held;
  } stab_t;

  typedef struct {
    int   cx, cy, cw, ch;
    int   expBeats;
    logic expErr;
  } winVec_t;

  beat_t   gotQ[$];
  beat_t   expQ[$];
  stab_t   stabQ[$];
  winVec_t vecs[5];

  logic  heldValid;
  beat_t heldBeat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_ready = toggleEn ? togglePhase : readyLevel;

  stream_crop #(
    .DATA_WIDTH(8),
    .NUM_CH    (1),
    .IMG_WIDTH (IW),
    .IMG_HEIGHT(IH),
    .CW        (CWB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_x   (cfg_x),
    .cfg_y   (cfg_y),
    .cfg_w   (cfg_w),
    .cfg_h   (cfg_h),
    .cfg_load(cfg_load),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sof   (s_sof),
    .s_eol   (s_eol),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sof   (m_sof),
    .m_eol   (m_eol),
    .m_eof   (m_eof),
    .cfg_err (cfg_err),
    .busy    (busy)
  );

  // Output ready alternates every cycle while toggling is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggleEn) togglePhase = ~togglePhase;
    end
  end

  // Collect completed output beats and record what a stalled beat looked
  // like one cycle later so the main sequence can check it did not move.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready)
      gotQ.push_back('{m_data, m_sof, m_eol, m_eof});
    if (!rst && heldValid && m_valid)
      stabQ.push_back('{cur: '{m_data, m_sof, m_eol, m_eof}, held: heldBeat});
    heldValid <= !rst && m_valid && !m_ready;
    heldBeat  <= '{m_data, m_sof, m_eol, m_eof};
  end

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic loadCfg(input int x, input int y, input int w, input int h);
    cfg_x    = CWB'(x);
    cfg_y    = CWB'(y);
    cfg_w    = CWB'(w);
    cfg_h    = CWB'(h);
    cfg_load = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  // Offer one beat and hold it until the DUT takes it, with a cycle budget.
  task automatic pushBeat(input logic [7:0] d, input logic sof, input logic eol);
    int n = 0;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkVal("inputAcceptTimeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  // Raster beats [first, first+count) of a frame; index 0 carries s_sof.
  task automatic applyStimulus(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      pushBeat(8'((i / IW) * 16 + (i % IW)), i == 0, (i % IW) == IW - 1);
    end
  endtask

  // Reference model: beats of the first nBeats raster positions inside the window.
  task automatic expectWindow(input int cx, input int cy, input int cw, input int ch, input int nBeats);
    for (int i = 0; i < nBeats; i++) begin
      int x = i % IW;
      int y = i / IW;
      if (x >= cx && x < cx + cw && y >= cy && y < cy + ch) begin
        beat_t b;
        b.data = 8'(y * 16 + x);
        b.sof  = (x == cx) && (y == cy);
        b.eol  = (x == cx + cw - 1);
        b.eof  = (x == cx + cw - 1) && (y == cy + ch - 1);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic waitIdle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    int n;
    checkVal({name, "_beatCount"}, 32'(gotQ.size()), 32'(expQ.size()));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkVal($sformatf("%s_beat%0d", name, i), 32'(gotQ[i]), 32'(expQ[i]));
    end
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    vecs[0] = '{2, 1, 3, 2, 6,  1'b0};
    vecs[1] = '{0, 0, 8, 6, 48, 1'b0};
    vecs[2] = '{7, 5, 1, 1, 1,  1'b0};
    vecs[3] = '{0, 0, 1, 6, 6,  1'b0};
    vecs[4] = '{5, 2, 3, 4, 12, 1'b0};

    rst = 1'b1;
    cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_load = 1'b0;
    s_data = '0; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkVal("rst_mValid", 32'(m_valid), 32'd0);
    checkVal("rst_mData", 32'(m_data), 32'd0);
    checkVal("rst_mFlags", 32'({m_sof, m_eol, m_eof}), 32'd0);
    checkVal("rst_cfgErr", 32'(cfg_err), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_sReady", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;

    // Beats before the first s_sof are dropped even with a valid window loaded
    loadCfg(0, 0, 8, 6);
    for (int i = 1; i < 6; i++) pushBeat(8'(i), 1'b0, 1'b0);
    waitIdle();
    checkOutput("preSof");

    // Table of windows, full frame each, ready always high
    for (int v = 0; v < 5; v++) begin
      loadCfg(vecs[v].cx, vecs[v].cy, vecs[v].cw, vecs[v].ch);
      applyStimulus(0, 48);
      waitIdle();
      checkVal($sformatf("vec%0d_count", v), 32'(gotQ.size()), 32'(vecs[v].expBeats));
      checkVal($sformatf("vec%0d_cfgErr", v), 32'(cfg_err), 32'(vecs[v].expErr));
      expectWindow(vecs[v].cx, vecs[v].cy, vecs[v].cw, vecs[v].ch, 48);
      checkOutput($sformatf("vec%0d", v));
    end

    // busy spans from s_sof to the last in-window pixel (index 20)
    loadCfg(2, 1, 3, 2);
    applyStimulus(0, 12);
    @(negedge clk);
    checkVal("busyMidWindow", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(12, 36);
    waitIdle();
    checkVal("busyAfterWindow", 32'(busy), 32'd0);
    expectWindow(2, 1, 3, 2, 48);
    checkOutput("busyFrame");

    // Backpressure: ready toggling, same sequence, stalled beats held stable
    stabQ.delete();
    toggleEn = 1'b1;
    applyStimulus(0, 48);
    waitIdle();
    toggleEn = 1'b0;
    waitIdle();
    expectWindow(2, 1, 3, 2, 48);
    checkOutput("toggle");
    checkVal("toggle_stallSeen", 32'(stabQ.size() > 0), 32'd1);
    foreach (stabQ[i]) checkVal($sformatf("toggle_stable%0d", i), 32'(stabQ[i].cur), 32'(stabQ[i].held));

    // Mid-frame reload only takes effect at the next frame
    applyStimulus(0, 20);
    loadCfg(0, 0, 8, 6);
    applyStimulus(20, 28);
    waitIdle();
    expectWindow(2, 1, 3, 2, 48);
    checkOutput("midLoadOld");
    applyStimulus(0, 48);
    waitIdle();
    expectWindow(0, 0, 8, 6, 48);
    checkOutput("midLoadNew");

    // Frame aborted after 10 beats: no eof for it, new frame complete
    applyStimulus(0, 10);
    applyStimulus(0, 48);
    waitIdle();
    expectWindow(0, 0, 8, 6, 10);
    expectWindow(0, 0, 8, 6, 48);
    checkOutput("abort");

    // cfg_load together with s_sof: old shadow applies, new one is pending
    cfg_x = CWB'(2); cfg_y = CWB'(1); cfg_w = CWB'(3); cfg_h = CWB'(2);
    cfg_load = 1'b1;
    pushBeat(8'h00, 1'b1, 1'b0);
    cfg_load = 1'b0;
    applyStimulus(1, 47);
    waitIdle();
    expectWindow(0, 0, 8, 6, 48);
    checkOutput("sameCycleOld");
    applyStimulus(0, 48);
    waitIdle();
    expectWindow(2, 1, 3, 2, 48);
    checkOutput("sameCycleNew");

    // Window running past the right edge: error, no output, sticky
    loadCfg(6, 0, 4, 2);
    applyStimulus(0, 48);
    waitIdle();
    checkOutput("badWin1");
    checkVal("badWin1_cfgErr", 32'(cfg_err), 32'd1);
    checkVal("badWin1_busy", 32'(busy), 32'd0);
    applyStimulus(0, 48);
    waitIdle();
    checkOutput("badWin2");
    checkVal("badWin2_cfgErr", 32'(cfg_err), 32'd1);

    // Reset while a beat is stalled on the output
    loadCfg(0, 0, 8, 6);
    readyLevel = 1'b0;
    pushBeat(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checkVal("stall_mValid", 32'(m_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkVal("postRst_mValid", 32'(m_valid), 32'd0);
    checkVal("postRst_cfgErr", 32'(cfg_err), 32'd0);
    checkVal("postRst_sReady", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    readyLevel = 1'b1;
    for (int i = 1; i < 6; i++) pushBeat(8'(i), 1'b0, 1'b0);
    waitIdle();
    checkOutput("postRstDrop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_crop.md
STREAM_CROP -- requirements
Module: stream_crop

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per channel.
REQ-002 SHALL have parameter NUM_CH, default 1, channels per pixel (1..4).
REQ-003 SHALL have parameter IMG_WIDTH, default 640, maximum input line length.
REQ-004 SHALL have parameter IMG_HEIGHT, default 480, maximum input frame height.
REQ-005 SHALL have parameter CW, default 10, coordinate width: clog2(max(IMG_WIDTH,IMG_HEIGHT)) or more.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: cfg_x, cfg_y, cfg_w, cfg_h  in  CW each  requested crop origin and size; cfg_load  in  1  capture cfg_* into shadow.
REQ-008 SHALL have ports: s_data  in  DATA_WIDTH*NUM_CH  pixel; s_valid  in  1; s_ready  out  1; s_sof  in  1  first pixel of frame; s_eol  in  1  last pixel of line.
REQ-009 SHALL have ports: m_data  out  DATA_WIDTH*NUM_CH; m_valid  out  1; m_ready  in  1; m_sof, m_eol, m_eof  out  1 each.
REQ-010 SHALL have ports: cfg_err  out  1  sticky flag, invalid window applied; busy  out  1  high between accepted s_sof and final in-window pixel.

Function
REQ-011 SHALL complete a transfer on either side only when valid and ready are both high in the same cycle.
REQ-012 SHALL drive s_ready = !m_valid || m_ready, with no dependence on s_valid.
REQ-013 SHALL count accepted pixels with x,y: an s_sof beat is (0,0); after s_eol or x==IMG_WIDTH-1, x->0 and y+1; y saturates at IMG_HEIGHT-1.
REQ-014 SHALL capture cfg_* into a shadow set on cfg_load and move the shadow to the active set only on an accepted s_sof beat; the active set is used for that beat onward.
REQ-015 SHALL treat the window as invalid when cfg_w==0, cfg_h==0, cfg_x+cfg_w>IMG_WIDTH or cfg_y+cfg_h>IMG_HEIGHT, with sums evaluated at CW+1 bits.
REQ-016 SHALL, for an invalid window at activation, set cfg_err and forward no pixels that frame.
REQ-017 SHALL forward a beat when ax<=x<ax+aw and ay<=y<ay+ah, and accept and drop out-of-window beats (no output).
REQ-018 SHALL present each forwarded beat on m_* exactly 1 cycle after acceptance, through a registered output stage, and hold m_* stable while m_valid && !m_ready.
REQ-019 SHALL assert m_sof on (ax,ay), m_eol on x==ax+aw-1, and m_eof on (ax+aw-1, ay+ah-1).
REQ-020 SHALL, on s_sof arriving mid-frame, restart counters, abandon the old frame without emitting m_eof, and begin the new frame normally.
REQ-021 SHALL, when cfg_load and an accepted s_sof occur in the same cycle, apply the previous shadow and make the new values pending.
REQ-022 SHALL drop all beats before the first s_sof after reset.
REQ-023 SHALL clear cfg_err only on rst.

Reset
REQ-024 SHALL, on rst high at a clk edge, set m_valid=0, m_sof=m_eol=m_eof=0, m_data=0, cfg_err=0, busy=0, x=y=0, shadow and active window all zero (invalid), and a waiting-for-sof state.
REQ-025 SHALL, on rst asserted mid-transfer, discard any held output beat; s_ready=1 in the first cycle after rst is released.

Structure
REQ-026 SHALL place coordinate width CW, the pixel-bus width function and the window-record typedef (x,y,w,h) in shared package img_pkg.
REQ-027 SHALL implement state WAIT_SOF/ACTIVE/DRAIN (DRAIN: past window, consuming until next s_sof) in the top module.
REQ-028 SHALL implement the output register stage as sub-module stream_reg_slice.

Verification
REQ-029 SHALL verify: 8x6 frame, window (2,1,3,2), m_ready=1 -> 6 beats of pixels (2..4,1),(2..4,2); m_sof on first, m_eol on 3rd and 6th, m_eof on 6th.
REQ-030 SHALL verify: same frame, m_ready toggling 1/0 each cycle -> identical 6-beat sequence, m_data stable while stalled, no loss or duplication.
REQ-031 SHALL verify: cfg_load of (0,0,8,6) mid-frame -> current frame still cropped with old window; next frame passes all 48 beats.
REQ-032 SHALL verify: window (6,0,4,2) with IMG_WIDTH=8 -> cfg_err=1, zero output beats, persists across frames until rst.
REQ-033 SHALL verify: s_sof after 10 beats of a frame -> counters restart, no m_eof for aborted frame, new frame output correct.
REQ-034 SHALL verify: rst asserted with m_valid=1 and m_ready=0 -> next cycle m_valid=0 and cfg_err=0, and pixels before next s_sof are dropped.
